// File: rtl/apb_pkg.sv
// Shared definitions for the APB master bridge: default bus widths,
// the bridge FSM state type and the slave-decode helper.
package apb_pkg;

  localparam int APB_AW = 9;
  localparam int APB_DW = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_e;

  // Slave index from an address: 0 -> slave 1, 1 -> slave 2 (address MSB).
  function automatic logic slave_idx(input logic [APB_AW-1:0] addr);
    return addr[APB_AW-1];
  endfunction

endpackage

// File: rtl/apb_if.sv
// Request-side and APB-side signal bundle of the bridge.
// master: the bridge's view; slave: the view of whatever drives requests
// and models the two APB slaves.
interface apb_if #(
  parameter int AW = 9,
  parameter int DW = 8
) ();
  // request bus
  logic          i_ptransfer;
  logic          i_pwrite;
  logic [AW-1:0] i_pwaddr;
  logic [DW-1:0] i_pwdata;
  logic [AW-1:0] i_praddr;
  logic [DW-1:0] o_prdata;
  logic          o_pslverr;
  logic          o_done;
  // APB bus
  logic [AW-1:0] o_paddr;
  logic          o_pwrite;
  logic [DW-1:0] o_pwdata;
  logic          o_psel1;
  logic          o_psel2;
  logic          o_penable;
  logic          i_pready;
  logic [DW-1:0] i_prdata1;
  logic [DW-1:0] i_prdata2;
  logic          i_pslverr;

  modport master (
    input  i_ptransfer, i_pwrite, i_pwaddr, i_pwdata, i_praddr,
    input  i_pready, i_prdata1, i_prdata2, i_pslverr,
    output o_prdata, o_pslverr, o_done,
    output o_paddr, o_pwrite, o_pwdata, o_psel1, o_psel2, o_penable
  );

  modport slave (
    output i_ptransfer, i_pwrite, i_pwaddr, i_pwdata, i_praddr,
    output i_pready, i_prdata1, i_prdata2, i_pslverr,
    input  o_prdata, o_pslverr, o_done,
    input  o_paddr, o_pwrite, o_pwdata, o_psel1, o_psel2, o_penable
  );
endinterface

// File: rtl/apb_timeout_ctr.sv
// ACCESS wait-state counter. Cleared while the bridge is in SETUP, counts
// every wait cycle; 'expired' flags the wait cycle that would bring the
// count up to LIMIT, so the bridge can force completion on that edge.
module apb_timeout_ctr #(
  parameter int LIMIT = 16
) (
  input  logic pclk,
  input  logic presetn,
  input  logic clear,
  input  logic inc,
  output logic expired
);
  localparam int CW = $clog2(LIMIT + 1);

  logic [CW-1:0] count_reg;

  // Wait-cycle count, restarted for every transfer.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      count_reg <= '0;
    end else if (clear) begin
      count_reg <= '0;
    end else if (inc) begin
      count_reg <= count_reg + 1'b1;
    end
  end

  assign expired = inc && (count_reg == CW'(LIMIT - 1));
endmodule

// File: rtl/apb_master_bridge.sv
// APB3 master bridge: turns single-cycle transfer requests into
// SETUP/ACCESS cycles toward two slaves decoded from the address MSB.
// Optional feature: define APB_TIMEOUT_EN to bound ACCESS wait states to
// TIMEOUT_CYC; a timed-out transfer completes with o_pslverr=1.
module apb_master_bridge
  import apb_pkg::*;
#(
  parameter int AW          = APB_AW,
  parameter int DW          = APB_DW,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic   pclk,
  input  logic   presetn,
  apb_if.master  bus
);
  apb_state_e    state_reg;
  logic [AW-1:0] paddr_reg;
  logic          pwrite_reg;
  logic [DW-1:0] pwdata_reg;
  logic          psel1_reg;
  logic          psel2_reg;
  logic          penable_reg;
  logic [DW-1:0] prdata_reg;
  logic          pslverr_reg;
  logic          done_reg;

  logic          timed_out;
  logic          complete;
  logic          take_req;
  logic [AW-1:0] req_addr;
  logic          req_slave;

`ifdef APB_TIMEOUT_EN
  logic expired;

  apb_timeout_ctr #(
    .LIMIT (TIMEOUT_CYC)
  ) u_timeout (
    .pclk    (pclk),
    .presetn (presetn),
    .clear   (state_reg == SETUP),
    .inc     ((state_reg == ACCESS) && !bus.i_pready),
    .expired (expired)
  );

  assign timed_out = expired;
`else
  // Without the timeout the limit has no meaning; keep it referenced.
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYC != 0);
  assign timed_out = 1'b0;
`endif

  assign complete  = (state_reg == ACCESS) && (bus.i_pready || timed_out);
  // A new request is only sampled when idle or on the completing edge.
  assign take_req  = bus.i_ptransfer && ((state_reg == IDLE) || complete);
  assign req_addr  = bus.i_pwrite ? bus.i_pwaddr : bus.i_praddr;
  assign req_slave = slave_idx(req_addr);

  // Bridge FSM with all bus and status outputs registered.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_reg   <= IDLE;
      paddr_reg   <= '0;
      pwrite_reg  <= 1'b0;
      pwdata_reg  <= '0;
      psel1_reg   <= 1'b0;
      psel2_reg   <= 1'b0;
      penable_reg <= 1'b0;
      prdata_reg  <= '0;
      pslverr_reg <= 1'b0;
      done_reg    <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: ;
        SETUP: begin
          penable_reg <= 1'b1;
          state_reg   <= ACCESS;
        end
        ACCESS: begin
          if (complete) begin
            done_reg    <= 1'b1;
            penable_reg <= 1'b0;
            psel1_reg   <= 1'b0;
            psel2_reg   <= 1'b0;
            state_reg   <= IDLE;
            if (timed_out) begin
              pslverr_reg <= 1'b1;
            end else begin
              pslverr_reg <= bus.i_pslverr;
              if (!pwrite_reg) begin
                prdata_reg <= slave_idx(paddr_reg) ? bus.i_prdata2 : bus.i_prdata1;
              end
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
      // Capture overrides the drop above, so psel stays up when the
      // next transfer targets the same slave.
      if (take_req) begin
        paddr_reg  <= req_addr;
        pwrite_reg <= bus.i_pwrite;
        pwdata_reg <= bus.i_pwdata;
        psel1_reg  <= !req_slave;
        psel2_reg  <= req_slave;
        state_reg  <= SETUP;
      end
    end
  end

  assign bus.o_paddr   = paddr_reg;
  assign bus.o_pwrite  = pwrite_reg;
  assign bus.o_pwdata  = pwdata_reg;
  assign bus.o_psel1   = psel1_reg;
  assign bus.o_psel2   = psel2_reg;
  assign bus.o_penable = penable_reg;
  assign bus.o_prdata  = prdata_reg;
  assign bus.o_pslverr = pslverr_reg;
  assign bus.o_done    = done_reg;
endmodule
